// File: rtl/enc_dec_sequencer_if.sv
// Bundle of host-side control/status and encoder/decoder datapath handshake signals
// for enc_dec_sequencer. slave = sequencer view, master = environment view.
interface enc_dec_sequencer_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic [1:0]            ctrl;
    logic [1:0]            codeword_width;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] noise;

    logic                  enc_start;
    logic [DATA_WIDTH-1:0] enc_din;
    logic [1:0]            enc_width;
    logic                  enc_done;
    logic [DATA_WIDTH-1:0] enc_dout;

    logic                  dec_start;
    logic [DATA_WIDTH-1:0] dec_din;
    logic [1:0]            dec_width;
    logic                  dec_done;
    logic [DATA_WIDTH-1:0] dec_dout;
    logic [1:0]            dec_num_err;

    logic [DATA_WIDTH-1:0] data_out;
    logic [1:0]            num_of_errors;
    logic                  busy;
    logic                  operation_done;
    logic                  err;

    modport slave (
        input  start, ctrl, codeword_width, data_in, noise,
        input  enc_done, enc_dout, dec_done, dec_dout, dec_num_err,
        output enc_start, enc_din, enc_width, dec_start, dec_din, dec_width,
        output data_out, num_of_errors, busy, operation_done, err
    );

    modport master (
        output start, ctrl, codeword_width, data_in, noise,
        output enc_done, enc_dout, dec_done, dec_dout, dec_num_err,
        input  enc_start, enc_din, enc_width, dec_start, dec_din, dec_width,
        input  data_out, num_of_errors, busy, operation_done, err
    );
endinterface

// File: rtl/enc_dec_sequencer.sv
// Sequences encode / decode / full-channel (encode, add noise, decode) operations.
// Optional ENC_DEC_TIMEOUT_EN adds a per-handshake watchdog of TIMEOUT_CYCLES.
module enc_dec_sequencer #(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic               clk,
    input  logic               rstn,
    enc_dec_sequencer_if.slave bus
);

    typedef enum logic [2:0] {IDLE, LATCH, ENC, NOISE, DEC, DONE} state_e;

    state_e                state_q, state_d;
    logic [1:0]            ctrl_q, width_q;
    logic [DATA_WIDTH-1:0] data_q, noise_q, enc_res_q;
    logic                  enc_start_q, dec_start_q;
    logic [DATA_WIDTH-1:0] enc_din_q, dec_din_q;
    logic [1:0]            enc_width_q, dec_width_q;
    logic [DATA_WIDTH-1:0] data_out_q;
    logic [1:0]            num_err_q;
    logic                  err_q;
    logic                  accept, reserved, timeout;

    // Keep only the low 8/16/32 bits selected by the width code.
    function automatic logic [DATA_WIDTH-1:0] width_mask(input logic [DATA_WIDTH-1:0] v,
                                                         input logic [1:0]            w);
        logic [DATA_WIDTH-1:0] m;
        m = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            m[i] = (i < (8 << w));
        end
        return v & m;
    endfunction

    assign accept   = (state_q == IDLE) && bus.start;
    assign reserved = (ctrl_q == 2'b11) || (width_q == 2'b11);

`ifdef ENC_DEC_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Restarts from zero on every entry into a wait state.
    always_comb begin
        cnt_d = '0;
        if ((state_q == ENC || state_q == DEC) && state_d == state_q) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT_CYCLES;
    assign timeout        = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (bus.start) state_d = LATCH;
            LATCH: begin
                if (reserved)              state_d = DONE;
                else if (ctrl_q == 2'b01)  state_d = DEC;
                else                       state_d = ENC;
            end
            ENC: begin
                if (bus.enc_done)          state_d = (ctrl_q == 2'b10) ? NOISE : DONE;
                else if (timeout)          state_d = DONE;
            end
            NOISE: state_d = DEC;
            DEC: begin
                if (bus.dec_done || timeout) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy           = (state_q != IDLE);
        bus.operation_done = (state_q == DONE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ctrl_q      <= '0;
            width_q     <= '0;
            data_q      <= '0;
            noise_q     <= '0;
            enc_res_q   <= '0;
            enc_start_q <= 1'b0;
            dec_start_q <= 1'b0;
            enc_din_q   <= '0;
            dec_din_q   <= '0;
            enc_width_q <= '0;
            dec_width_q <= '0;
            data_out_q  <= '0;
            num_err_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            enc_start_q <= (state_q != ENC) && (state_d == ENC);
            dec_start_q <= (state_q != DEC) && (state_d == DEC);
            if (accept) begin
                ctrl_q     <= bus.ctrl;
                width_q    <= bus.codeword_width;
                data_q     <= bus.data_in;
                noise_q    <= bus.noise;
                data_out_q <= '0;
                num_err_q  <= '0;
                err_q      <= 1'b0;
            end
            case (state_q)
                LATCH: begin
                    if (reserved) begin
                        err_q <= 1'b1;
                    end else if (ctrl_q == 2'b01) begin
                        dec_din_q   <= width_mask(data_q, width_q);
                        dec_width_q <= width_q;
                    end else begin
                        enc_din_q   <= width_mask(data_q, width_q);
                        enc_width_q <= width_q;
                    end
                end
                ENC: begin
                    if (bus.enc_done) begin
                        enc_res_q <= bus.enc_dout;
                        if (ctrl_q == 2'b00) data_out_q <= bus.enc_dout;
                    end else if (timeout) begin
                        err_q      <= 1'b1;
                        data_out_q <= '0;
                    end
                end
                // Channel noise is applied to the captured codeword before decoding.
                NOISE: begin
                    dec_din_q   <= width_mask(enc_res_q ^ noise_q, width_q);
                    dec_width_q <= width_q;
                end
                DEC: begin
                    if (bus.dec_done) begin
                        data_out_q <= bus.dec_dout;
                        num_err_q  <= bus.dec_num_err;
                    end else if (timeout) begin
                        err_q      <= 1'b1;
                        data_out_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.enc_start     = enc_start_q;
    assign bus.dec_start     = dec_start_q;
    assign bus.enc_din       = enc_din_q;
    assign bus.dec_din       = dec_din_q;
    assign bus.enc_width     = enc_width_q;
    assign bus.dec_width     = dec_width_q;
    assign bus.data_out      = data_out_q;
    assign bus.num_of_errors = num_err_q;
    assign bus.err           = err_q;

endmodule

// File: tb/tb_enc_dec_sequencer.sv
// Bench for enc_dec_sequencer: a per-cycle stimulus/expectation timeline is planned from
// transaction-level rules, then replayed and compared every cycle.
module tb_enc_dec_sequencer;
    localparam int DW = 32;
    localparam int TO = 64;
    localparam int NC = 3000;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    enc_dec_sequencer_if #(.DATA_WIDTH(DW)) bus();

    enc_dec_sequencer #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus.slave)
    );

    // Planned stimulus per cycle
    bit          a_rst[NC], a_start[NC], a_ed[NC], a_dd[NC];
    bit   [1:0]  a_ctrl[NC], a_w[NC], a_ne[NC];
    logic [31:0] a_data[NC], a_noise[NC], a_edout[NC], a_ddout[NC];
    // Expected outputs per cycle
    bit          e_busy[NC], e_opd[NC], e_es[NC], e_ds[NC], e_err[NC];
    bit   [1:0]  e_encw[NC], e_decw[NC], e_num[NC];
    logic [31:0] e_encdin[NC], e_decdin[NC], e_dout[NC];

    int n_checks = 0;
    int n_pass   = 0;
    int cur_k    = 0;
    bit running  = 1'b0;

    function automatic logic [31:0] m_mask(input logic [31:0] v, input bit [1:0] w);
        longint unsigned lim;
        lim = 64'd1 << (8 << w);
        return 32'(64'(v) % lim);
    endfunction

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s cycle %0d: got %h expected %h", name, k, act, exp);
        else n_pass++;
    endtask

    // Plan one transaction starting at c0; returns the operation_done cycle.
    task automatic plan_tx(input int c0, input bit [1:0] ctrl, input bit [1:0] w,
                           input logic [31:0] data, input logic [31:0] noise,
                           input logic [31:0] encres, input logic [31:0] decres,
                           input bit [1:0] ne, input int le, input int ld,
                           input int rst_off, input bit spur, output int cd);
        int es, ed, ds, dd, rc, last;
        logic [31:0] rd;
        bit   [1:0]  rn;
        bit          re;
        ds = -1; rd = '0; rn = '0; re = 1'b0; cd = c0 + 2;
        a_start[c0] = 1'b1; a_ctrl[c0] = ctrl; a_w[c0] = w;
        a_data[c0] = data; a_noise[c0] = noise;
        if (ctrl == 2'b11 || w == 2'b11) begin
            cd = c0 + 2; re = 1'b1;
        end else begin
            if (ctrl != 2'b01) begin
                es = c0 + 2;
                e_es[es] = 1'b1; e_encdin[es] = m_mask(data, w); e_encw[es] = w;
                if (le < 0) begin
                    for (int c = es; c < es + TO; c++) a_ed[c] = 1'b0;
                    cd = es + TO; re = 1'b1;
                end else begin
                    ed = es + le;
                    for (int c = es; c < ed; c++) a_ed[c] = 1'b0;
                    a_ed[ed] = 1'b1; a_edout[ed] = encres;
                    if (ctrl == 2'b00) begin cd = ed + 1; rd = encres; end
                    else ds = ed + 2;
                end
            end else begin
                ds = c0 + 2;
            end
            if (ds >= 0) begin
                dd = ds + ld;
                for (int c = ds; c < dd; c++) a_dd[c] = 1'b0;
                a_dd[dd] = 1'b1; a_ddout[dd] = decres; a_ne[dd] = ne;
                e_ds[ds] = 1'b1; e_decw[ds] = w;
                e_decdin[ds] = (ctrl == 2'b01) ? m_mask(data, w) : m_mask(encres ^ noise, w);
                cd = dd + 1; rd = decres; rn = ne;
            end
        end
        for (int c = c0 + 1; c <= cd; c++) e_busy[c] = 1'b1;
        e_opd[cd] = 1'b1;
        for (int c = c0 + 1; c < cd; c++) begin e_dout[c] = '0; e_num[c] = '0; e_err[c] = 1'b0; end
        for (int c = cd; c < NC; c++) begin e_dout[c] = rd; e_num[c] = rn; e_err[c] = re; end
        rc = (rst_off >= 0 && ds >= 0) ? ds + rst_off : -1;
        if (rc >= 0) begin
            a_rst[rc] = 1'b1;
            for (int c = rc; c < NC; c++) begin
                e_busy[c] = 0; e_opd[c] = 0; e_es[c] = 0; e_ds[c] = 0;
                e_dout[c] = '0; e_num[c] = '0; e_err[c] = 0;
            end
        end
        last = (rc >= 0) ? rc - 1 : cd;
        if (spur) begin
            for (int c = c0 + 1; c <= last; c++) if ($urandom % 3 == 0) a_start[c] = 1'b1;
        end
    endtask

    task automatic apply(input int k);
        cur_k              = k;
        rstn               = !a_rst[k];
        bus.start          = a_start[k];
        bus.ctrl           = a_ctrl[k];
        bus.codeword_width = a_w[k];
        bus.data_in        = a_data[k];
        bus.noise          = a_noise[k];
        bus.enc_done       = a_ed[k];
        bus.enc_dout       = a_edout[k];
        bus.dec_done       = a_dd[k];
        bus.dec_dout       = a_ddout[k];
        bus.dec_num_err    = a_ne[k];
    endtask

    always @(negedge clk) begin
        if (running && cur_k >= 1) begin
            chk("busy",           cur_k, 32'(bus.busy),           32'(e_busy[cur_k]));
            chk("operation_done", cur_k, 32'(bus.operation_done), 32'(e_opd[cur_k]));
            chk("enc_start",      cur_k, 32'(bus.enc_start),      32'(e_es[cur_k]));
            chk("dec_start",      cur_k, 32'(bus.dec_start),      32'(e_ds[cur_k]));
            chk("data_out",       cur_k, bus.data_out,            e_dout[cur_k]);
            chk("num_of_errors",  cur_k, 32'(bus.num_of_errors),  32'(e_num[cur_k]));
            chk("err",            cur_k, 32'(bus.err),            32'(e_err[cur_k]));
            if (e_es[cur_k]) begin
                chk("enc_din",   cur_k, bus.enc_din,         e_encdin[cur_k]);
                chk("enc_width", cur_k, 32'(bus.enc_width),  32'(e_encw[cur_k]));
            end
            if (e_ds[cur_k]) begin
                chk("dec_din",   cur_k, bus.dec_din,         e_decdin[cur_k]);
                chk("dec_width", cur_k, 32'(bus.dec_width),  32'(e_decw[cur_k]));
            end
        end
    end

    initial begin
        int c, cd, le, ld, ro, last;
        bit [1:0] ct, w;
        for (int k = 0; k < NC; k++) begin
            a_rst[k] = 0; a_start[k] = 0;
            a_ctrl[k] = 2'($urandom); a_w[k] = 2'($urandom); a_ne[k] = 2'($urandom);
            a_data[k] = $urandom; a_noise[k] = $urandom;
            a_ed[k] = ($urandom % 4 == 0); a_dd[k] = ($urandom % 4 == 0);
            a_edout[k] = $urandom; a_ddout[k] = $urandom;
            e_busy[k] = 0; e_opd[k] = 0; e_es[k] = 0; e_ds[k] = 0; e_err[k] = 0;
            e_encw[k] = 0; e_decw[k] = 0; e_num[k] = 0;
            e_encdin[k] = '0; e_decdin[k] = '0; e_dout[k] = '0;
        end
        a_rst[0] = 1; a_rst[1] = 1;

        c = 3;
        plan_tx(c, 2'b00, 2'b00, 32'h0B, $urandom, 32'h5A, $urandom, 2'd0, 3, 1, -1, 0, cd);
        chk("pin_enc_done_cycle", c, 32'(cd - c), 32'd6);
        chk("pin_enc_din", c, e_encdin[c + 2], 32'h0B);
        chk("pin_enc_result", c, e_dout[cd], 32'h5A);

        c = cd + 2;
        plan_tx(c, 2'b10, 2'b00, $urandom, 32'h104, 32'h5A, 32'h0B, 2'd1, 2, 2, -1, 0, cd);
        chk("pin_noise_dec_din", c, e_decdin[c + 6], 32'h5E);
        chk("pin_full_result", c, e_dout[cd], 32'h0B);
        chk("pin_full_nerr", c, 32'(e_num[cd]), 32'd1);

        c = cd + 2;
        plan_tx(c, 2'b11, 2'b00, $urandom, $urandom, $urandom, $urandom, 2'd0, 1, 1, -1, 0, cd);
        chk("pin_reserved_cycle", c, 32'(cd - c), 32'd2);
        chk("pin_reserved_err", c, 32'(e_err[cd]), 32'd1);

        c = cd + 2;
        plan_tx(c, 2'b00, 2'b01, $urandom, $urandom, $urandom, $urandom, 2'd0, 4, 1, -1, 0, cd);
        a_start[c + 3] = 1'b1; a_ctrl[c + 3] = 2'b01;

        c = cd + 2;
        plan_tx(c, 2'b01, 2'b10, $urandom, $urandom, $urandom, $urandom, 2'd2, 1, 4, 2, 0, cd);
        chk("pin_reset_busy", c, 32'(e_busy[c + 4]), 32'd0);

        c = cd + 1;
        plan_tx(c, 2'b00, 2'b10, $urandom, $urandom, $urandom, $urandom, 2'd0, 0, 0, -1, 0, cd);

`ifdef ENC_DEC_TIMEOUT_EN
        c = cd + 2;
        plan_tx(c, 2'b00, 2'b00, $urandom, $urandom, $urandom, $urandom, 2'd0, -1, 0, -1, 0, cd);
        chk("pin_timeout_cycle", c, 32'(cd - (c + 2)), 32'(TO));
`endif

        c = cd + 2;
        while (c < NC - 120) begin
            ct = 2'($urandom);
            w  = ($urandom % 8 == 0) ? 2'b11 : 2'($urandom % 3);
            le = int'($urandom % 5);
            ld = int'($urandom % 5);
            ro = ($urandom % 6 == 0) ? int'($urandom_range(0, ld)) : -1;
            plan_tx(c, ct, w, $urandom, $urandom, $urandom, $urandom, 2'($urandom),
                    le, ld, ro, 1'b1, cd);
            c = cd + 1 + int'($urandom % 3);
        end

        last    = c + 10;
        running = 1'b1;
        for (int k = 0; k < last; k++) begin
            apply(k);
            @(posedge clk);
            #1;
        end
        running = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
